// File: rtl/adc_spi_capture_pkg.sv
// Shared types and default sizing for the ADC SPI capture block.
package adc_spi_capture_pkg;

  localparam int unsigned ADC_DATA_W     = 12;
  localparam int unsigned ADC_FRAME_BITS = 16;
  localparam int unsigned ADC_QUIET_CYC  = 2;
  localparam int unsigned ADC_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StTail,
    StQuiet
  } adc_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset; Depth must be a power of 2 (>= 2).
module sync_fifo #(
  parameter int unsigned Width = 12,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AddrW+1)'(Depth));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so push succeeds even when full.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/adc_spi_capture.sv
// Continuous serial ADC frame capture: drives CS_n, shifts SDATA on SCLK rising strobes,
// checks leading zeros and buffers samples in a small FIFO.
module adc_spi_capture
  import adc_spi_capture_pkg::*;
#(
  parameter int unsigned DATA_W     = ADC_DATA_W,
  parameter int unsigned FRAME_BITS = ADC_FRAME_BITS,
  parameter int unsigned QUIET_CYC  = ADC_QUIET_CYC,
  parameter int unsigned FIFO_DEPTH = ADC_FIFO_DEPTH
) (
  input  logic              clk_clk,
  input  logic              reset,
  input  logic              pe_sclk,
  input  logic              ne_sclk,
  input  logic              enable,
  input  logic              adc_sdata,
  output logic              adc_cs_n,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic              frame_err,
  input  logic              clr_flags
);

  localparam int unsigned BitCntW   = $clog2(FRAME_BITS);
  localparam int unsigned QuietCntW = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;
  localparam logic [BitCntW-1:0]   LastBit   = BitCntW'(FRAME_BITS - 1);
  localparam logic [QuietCntW-1:0] LastQuiet = QuietCntW'(QUIET_CYC - 1);

  adc_state_e             state_q, state_d;
  logic                   cs_n_q, cs_n_d;
  logic [BitCntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [QuietCntW-1:0]   quiet_cnt_q, quiet_cnt_d;
  logic [FRAME_BITS-1:0]  shreg_q, shreg_d;
  logic                   push_q, push_d;
  logic                   overrun_q, overrun_d;
  logic                   frame_err_q, frame_err_d;
  logic                   ne_only;
  logic                   fifo_full, fifo_empty, fifo_pop;

  // A coincident rising strobe takes priority over the falling one.
  assign ne_only = ne_sclk && !pe_sclk;

  always_comb begin
    state_d     = state_q;
    cs_n_d      = cs_n_q;
    bit_cnt_d   = bit_cnt_q;
    quiet_cnt_d = quiet_cnt_q;
    shreg_d     = shreg_q;
    push_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable && ne_only) begin
          state_d   = StShift;
          cs_n_d    = 1'b0;
          bit_cnt_d = '0;
        end
      end
      StShift: begin
        if (pe_sclk) begin
          shreg_d   = {shreg_q[FRAME_BITS-2:0], adc_sdata};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LastBit) begin
            state_d = StTail;
            push_d  = 1'b1;
          end
        end
      end
      StTail: begin
        if (ne_only) begin
          state_d     = StQuiet;
          cs_n_d      = 1'b1;
          quiet_cnt_d = '0;
        end
      end
      StQuiet: begin
        if (ne_only) begin
          quiet_cnt_d = quiet_cnt_q + 1'b1;
          if (quiet_cnt_q == LastQuiet) begin
            if (enable) begin
              state_d   = StShift;
              cs_n_d    = 1'b0;
              bit_cnt_d = '0;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // shreg is frozen outside StShift, so it still holds the completed word during push_q.
  always_comb begin
    overrun_d   = (overrun_q && !clr_flags) || (push_q && fifo_full && !fifo_pop);
    frame_err_d = (frame_err_q && !clr_flags) ||
                  (push_q && (|shreg_q[FRAME_BITS-1:DATA_W]));
  end

  always_ff @(posedge clk_clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cs_n_q      <= 1'b1;
      bit_cnt_q   <= '0;
      quiet_cnt_q <= '0;
      shreg_q     <= '0;
      push_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_n_q      <= cs_n_d;
      bit_cnt_q   <= bit_cnt_d;
      quiet_cnt_q <= quiet_cnt_d;
      shreg_q     <= shreg_d;
      push_q      <= push_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign fifo_pop  = out_valid && out_ready;
  assign out_valid = !fifo_empty;
  assign adc_cs_n  = cs_n_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

  sync_fifo #(
    .Width(DATA_W),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_clk),
    .rst_i  (reset),
    .push_i (push_q),
    .data_i (shreg_q[DATA_W-1:0]),
    .pop_i  (fifo_pop),
    .data_o (out_data),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

endmodule
